// File: rtl/barrel_shift_pipe_if.sv
// barrel_shift_pipe_if: valid/ready operand and result bundle for barrel_shift_pipe; SHIFT_ZN_FLAGS_EN adds out_zero/out_neg
interface barrel_shift_pipe_if #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] shift_data;
    logic [AMT_W-1:0]  shift_num;
    logic [2:0]        shift_op;
    logic              carry_flag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] shift_out;
    logic              shift_carry_out;
`ifdef SHIFT_ZN_FLAGS_EN
    logic              out_zero;
    logic              out_neg;
    modport master (
        output in_valid, shift_data, shift_num, shift_op, carry_flag, out_ready,
        input  in_ready, out_valid, shift_out, shift_carry_out, out_zero, out_neg
    );
    modport slave (
        input  in_valid, shift_data, shift_num, shift_op, carry_flag, out_ready,
        output in_ready, out_valid, shift_out, shift_carry_out, out_zero, out_neg
    );
`else
    modport master (
        output in_valid, shift_data, shift_num, shift_op, carry_flag, out_ready,
        input  in_ready, out_valid, shift_out, shift_carry_out
    );
    modport slave (
        input  in_valid, shift_data, shift_num, shift_op, carry_flag, out_ready,
        output in_ready, out_valid, shift_out, shift_carry_out
    );
`endif
endinterface

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: two-stage ARM shifter (LSL/LSR/ASR/ROR/RRX) with carry-out; SHIFT_ZN_FLAGS_EN adds registered Z/N flags
module barrel_shift_pipe #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 8
) (
    input logic clk,
    input logic rst_n,
    barrel_shift_pipe_if.slave bus
);
    localparam int L = $clog2(DATA_W);
    localparam logic [1:0] K_LSL = 2'd0, K_LSR = 2'd1, K_ASR = 2'd2, K_ROR = 2'd3;
    typedef enum logic [2:0] {SP_NONE, SP_ZERO, SP_FULL, SP_OVER, SP_RRX} special_t;

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic              s1_cf_q, s1_cf_d;
    logic [1:0]        s1_kind_q, s1_kind_d;
    logic [L-1:0]      s1_amt_q, s1_amt_d;
    special_t          s1_spec_q, s1_spec_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] shift_out_q, shift_out_d;
    logic              carry_q, carry_d;
    logic              s2_advance, accept, s2_load;
    logic [L-1:0]      n_lo;
    logic              n_zero, n_full, n_over;
    logic [DATA_W:0]   l, r;
    logic [DATA_W-1:0] o, res;
    logic              fill, sign, res_c;

    assign s2_advance      = !out_valid_q | bus.out_ready;
    assign bus.in_ready    = !s1_valid_q | s2_advance;
    assign accept          = bus.in_valid & bus.in_ready;
    assign s2_load         = s2_advance & s1_valid_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.shift_out   = shift_out_q;
    assign bus.shift_carry_out = carry_q;

    // stage 1: capture operand and reduce op/amount to {kind, amount, special case}
    always_comb begin
        n_lo       = bus.shift_num[L-1:0];
        n_zero     = bus.shift_num == '0;
        n_full     = bus.shift_num == AMT_W'(DATA_W);
        n_over     = bus.shift_num > AMT_W'(DATA_W);
        s1_valid_d = bus.in_ready ? bus.in_valid : s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_cf_d    = s1_cf_q;
        s1_kind_d  = s1_kind_q;
        s1_amt_d   = s1_amt_q;
        s1_spec_d  = s1_spec_q;
        if (accept) begin
            s1_data_d = bus.shift_data;
            s1_cf_d   = bus.carry_flag;
            s1_kind_d = bus.shift_op[2:1];
            s1_amt_d  = n_lo;
            if (!bus.shift_op[0])
                s1_spec_d = n_lo != '0 ? SP_NONE :
                            bus.shift_op[2:1] == K_LSL ? SP_ZERO :
                            bus.shift_op[2:1] == K_ROR ? SP_RRX : SP_FULL;
            else if (bus.shift_op[2:1] == K_ROR)
                s1_spec_d = n_zero ? SP_ZERO : n_lo == '0 ? SP_FULL : SP_NONE;
            else
                s1_spec_d = n_zero ? SP_ZERO : n_full ? SP_FULL : n_over ? SP_OVER : SP_NONE;
        end
    end

    // stage 2: log2(DATA_W) mux layers; extra bit beside the operand catches the carry
    always_comb begin
        sign = s1_data_q[DATA_W-1];
        fill = (s1_kind_q == K_ASR) & sign;
        l    = {1'b0, s1_data_q};
        r    = {s1_data_q, 1'b0};
        o    = s1_data_q;
        for (int k = 0; k < L; k++) begin
            if (s1_amt_q[k]) begin
                l = l << (1 << k);
                r = (r >> (1 << k)) | (fill ? ~({(DATA_W+1){1'b1}} >> (1 << k)) : '0);
                o = (o >> (1 << k)) | (o << (DATA_W - (1 << k)));
            end
        end
        res   = s1_data_q;
        res_c = s1_cf_q;
        case (s1_spec_q)
            SP_NONE: begin
                res   = s1_kind_q == K_LSL ? l[DATA_W-1:0] : s1_kind_q == K_ROR ? o : r[DATA_W:1];
                res_c = s1_kind_q == K_LSL ? l[DATA_W] : s1_kind_q == K_ROR ? o[DATA_W-1] : r[0];
            end
            SP_RRX: begin
                res   = {s1_cf_q, s1_data_q[DATA_W-1:1]};
                res_c = s1_data_q[0];
            end
            SP_FULL: begin
                res   = s1_kind_q == K_ASR ? {DATA_W{sign}} : s1_kind_q == K_ROR ? s1_data_q : '0;
                res_c = s1_kind_q == K_LSL ? s1_data_q[0] : sign;
            end
            SP_OVER: begin
                res   = s1_kind_q == K_ASR ? {DATA_W{sign}} : '0;
                res_c = (s1_kind_q == K_ASR) & sign;
            end
            default: ;
        endcase
        out_valid_d = s2_advance ? s1_valid_q : out_valid_q;
        shift_out_d = s2_load ? res : shift_out_q;
        carry_d     = s2_load ? res_c : carry_q;
    end

    // pipeline registers; reset discards every in-flight beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_cf_q     <= 1'b0;
            s1_kind_q   <= '0;
            s1_amt_q    <= '0;
            s1_spec_q   <= SP_NONE;
            out_valid_q <= 1'b0;
            shift_out_q <= '0;
            carry_q     <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_cf_q     <= s1_cf_d;
            s1_kind_q   <= s1_kind_d;
            s1_amt_q    <= s1_amt_d;
            s1_spec_q   <= s1_spec_d;
            out_valid_q <= out_valid_d;
            shift_out_q <= shift_out_d;
            carry_q     <= carry_d;
        end
    end

`ifdef SHIFT_ZN_FLAGS_EN
    logic zero_q, zero_d, neg_q, neg_d;
    assign bus.out_zero = zero_q;
    assign bus.out_neg  = neg_q;

    // Z/N flags follow the result register, including stalls
    always_comb begin
        zero_d = s2_load ? (res == '0) : zero_q;
        neg_d  = s2_load ? res[DATA_W-1] : neg_q;
    end

    // flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end
`endif
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb_barrel_shift_pipe: randomized and directed checks of barrel_shift_pipe against a behavioural shifter model
module tb_barrel_shift_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int fails = 0;
    logic [1:0] zn32;

    always #5 clk = ~clk;

    barrel_shift_pipe_if #(.DATA_W(32), .AMT_W(8)) b32();
    barrel_shift_pipe_if #(.DATA_W(16), .AMT_W(8)) b16();
    barrel_shift_pipe #(.DATA_W(32), .AMT_W(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    barrel_shift_pipe #(.DATA_W(16), .AMT_W(8)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    // ARM shifter semantics straight from the operation table; returns {carry, result}
    function automatic logic [64:0] model(input int w, input logic [2:0] op, input logic [63:0] din, input int n, input logic cf);
        logic [63:0] m, d, r;
        logic c, s;
        int k;
        m = (64'd1 << w) - 64'd1;
        d = din & m;
        s = d[w-1];
        k = op[0] ? n : n % w;
        r = d;
        c = cf;
        case (op)
            3'b000, 3'b001: begin
                if (k >= 1 && k < w) begin r = (d << k) & m; c = d[w-k]; end
                else if (k == w) begin r = 64'd0; c = d[0]; end
                else if (k > w) begin r = 64'd0; c = 1'b0; end
            end
            3'b010, 3'b011: begin
                if (!op[0] && k == 0) k = w;
                if (k >= 1 && k < w) begin r = d >> k; c = d[k-1]; end
                else if (k == w) begin r = 64'd0; c = d[w-1]; end
                else if (k > w) begin r = 64'd0; c = 1'b0; end
            end
            3'b100, 3'b101: begin
                if (!op[0] && k == 0) k = w;
                if (k >= 1 && k < w) begin r = (d >> k) | (s ? (m & ~(m >> k)) : 64'd0); c = d[k-1]; end
                else if (k >= w) begin r = s ? m : 64'd0; c = s; end
            end
            3'b110: begin
                if (k == 0) begin r = ({63'd0, cf} << (w - 1)) | (d >> 1); c = d[0]; end
                else begin r = ((d >> k) | (d << (w - k))) & m; c = d[k-1]; end
            end
            default: begin
                if (n != 0) begin
                    k = n % w;
                    r = ((d >> k) | (d << (w - k))) & m;
                    c = r[w-1];
                end
            end
        endcase
        return {c, r};
    endfunction

    function automatic logic [7:0] pick_amt();
        case ($urandom_range(0, 5))
            0: return 8'd0;
            1: return 8'd32;
            2: return 8'd33;
            3: return 8'd31;
            4: return 8'd64;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic tick32(input logic v, input logic [2:0] op, input logic [31:0] d, input logic [7:0] n, input logic cf,
                          input logic ordy, output logic acc, output logic cons, output logic [32:0] got);
        @(negedge clk);
        b32.in_valid = v; b32.shift_op = op; b32.shift_data = d; b32.shift_num = n; b32.carry_flag = cf; b32.out_ready = ordy;
        #1;
        acc  = v & b32.in_ready;
        cons = b32.out_valid & ordy;
        got  = {b32.shift_carry_out, b32.shift_out};
`ifdef SHIFT_ZN_FLAGS_EN
        zn32 = {b32.out_neg, b32.out_zero};
`else
        zn32 = 2'b00;
`endif
        @(posedge clk);
    endtask

    task automatic tick16(input logic v, input logic [2:0] op, input logic [15:0] d, input logic [7:0] n, input logic cf,
                          input logic ordy, output logic acc, output logic cons, output logic [16:0] got);
        @(negedge clk);
        b16.in_valid = v; b16.shift_op = op; b16.shift_data = d; b16.shift_num = n; b16.carry_flag = cf; b16.out_ready = ordy;
        #1;
        acc  = v & b16.in_ready;
        cons = b16.out_valid & ordy;
        got  = {b16.shift_carry_out, b16.shift_out};
        @(posedge clk);
    endtask

    task automatic test_reset();
        logic acc, cons;
        logic [32:0] got;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick32(1'b1, 3'b000, 32'h8000_0001, 8'd1, 1'b0, 1'b1, acc, cons, got);
            checks++;
            if (cons !== 1'b0 || got !== 33'd0) begin
                fails++;
                $display("FAIL reset_hold: out_valid=%b {c,out}=%h, required 0/0", cons, got);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        b32.in_valid = 1'b1; b32.shift_op = 3'b000; b32.shift_data = 32'h8000_0001; b32.shift_num = 8'd1; b32.carry_flag = 1'b0; b32.out_ready = 1'b1;
        #1;
        checks++;
        if (b32.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b, required 1", b32.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        b32.in_valid = 1'b0;
        #1;
        checks++;
        if (b32.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_latency1: out_valid=%b, required 0", b32.out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (b32.out_valid !== 1'b1 || b32.shift_out !== 32'h2 || b32.shift_carry_out !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_beat: valid=%b out=%h c=%b, required 1/00000002/1", b32.out_valid, b32.shift_out, b32.shift_carry_out);
        end
        @(posedge clk);
    endtask

    task automatic test_directed();
        logic [2:0]  ops  [8] = '{3'b000, 3'b000, 3'b001, 3'b011, 3'b101, 3'b111, 3'b110, 3'b110};
        logic [31:0] dats [8] = '{32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h8000_0001, 32'h3, 32'h3};
        logic [7:0]  amts [8] = '{8'd1, 8'd0, 8'd32, 8'd33, 8'd200, 8'd64, 8'd0, 8'd4};
        logic        cfs  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [32:0] exps [8] = '{{1'b1, 32'h2}, {1'b0, 32'h8000_0001}, {1'b1, 32'h0}, {1'b0, 32'h0},
                                  {1'b1, 32'hFFFF_FFFF}, {1'b1, 32'h8000_0001}, {1'b1, 32'h8000_0001}, {1'b0, 32'h3000_0000}};
        logic acc, cons;
        logic [32:0] got;
        int sent = 0, rcvd = 0, s;
        for (int cyc = 0; cyc < 50 && rcvd < 8; cyc++) begin
            s = sent < 8 ? sent : 7;
            tick32(sent < 8, ops[s], dats[s], amts[s], cfs[s], 1'b1, acc, cons, got);
            if (cons) begin
                checks++;
                if (got !== exps[rcvd]) begin
                    fails++;
                    $display("FAIL directed_%0d: {c,out}=%h, required %h", rcvd, got, exps[rcvd]);
                end
                rcvd++;
            end
            if (acc) sent++;
        end
        checks++;
        if (rcvd != 8) begin
            fails++;
            $display("FAIL directed_timeout: received %0d, required 8", rcvd);
        end
    endtask

    task automatic test_back_pressure();
        logic [32:0] expq[$];
        logic [32:0] held, e;
        logic [64:0] m;
        logic [31:0] d;
        logic [7:0] n;
        logic acc, cons, v, cf;
        logic [32:0] got;
        int sent = 0, rcvd = 0;
        d = $urandom; n = pick_amt(); cf = 1'($urandom);
        for (int cyc = 0; cyc < 40 && rcvd < 4; cyc++) begin
            v = sent < 4;
            tick32(v, 3'b111, d, n, cf, !(cyc >= 2 && cyc <= 4), acc, cons, got);
            if (cyc >= 2 && cyc <= 4) begin
                checks++;
                if (acc !== 1'b0) begin
                    fails++;
                    $display("FAIL bp_in_ready: cycle %0d accepted, required in_ready=0", cyc);
                end
                if (cyc == 2) held = got;
                else begin
                    checks++;
                    if (got !== held) begin
                        fails++;
                        $display("FAIL bp_hold: cycle %0d out=%h, required %h", cyc, got, held);
                    end
                end
            end
            if (cons) begin
                e = expq.size() > 0 ? expq.pop_front() : 33'h0;
                checks++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL bp_order_%0d: {c,out}=%h, required %h", rcvd, got, e);
                end
                rcvd++;
            end
            if (acc) begin
                m = model(32, 3'b111, {32'd0, d}, int'(n), cf);
                expq.push_back({m[64], m[31:0]});
                sent++;
                d = $urandom; n = pick_amt(); cf = 1'($urandom);
            end
        end
        checks++;
        if (rcvd != 4 || expq.size() != 0) begin
            fails++;
            $display("FAIL bp_count: delivered %0d with %0d pending, required 4 and 0", rcvd, expq.size());
        end
    endtask

    task automatic test_random();
        logic [32:0] expq[$];
        logic [32:0] e;
        logic [64:0] m;
        logic [31:0] d;
        logic [7:0] n;
        logic [2:0] op;
        logic acc, cons, v, cf, ordy;
        logic [32:0] got;
        int errs = 0;
        for (int cyc = 0; cyc < 420; cyc++) begin
            v = cyc < 400 && $urandom_range(0, 3) != 0;
            ordy = cyc >= 400 || $urandom_range(0, 9) < 7;
            op = 3'($urandom); d = $urandom; n = pick_amt(); cf = 1'($urandom);
            tick32(v, op, d, n, cf, ordy, acc, cons, got);
            if (cons) begin
                e = expq.size() > 0 ? expq.pop_front() : 33'h0;
                checks++;
                if (got !== e) begin
                    fails++;
                    if (errs++ < 10) $display("FAIL random32: {c,out}=%h, required %h", got, e);
                end
`ifdef SHIFT_ZN_FLAGS_EN
                checks++;
                if (zn32 !== {e[31], e[31:0] == 32'd0}) begin
                    fails++;
                    $display("FAIL random32_zn: {n,z}=%b, required %b", zn32, {e[31], e[31:0] == 32'd0});
                end
`endif
            end
            if (acc) begin
                m = model(32, op, {32'd0, d}, int'(n), cf);
                expq.push_back({m[64], m[31:0]});
            end
        end
        checks++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL random32_drain: %0d results missing, required 0", expq.size());
        end
    endtask

    task automatic test_w16();
        logic [16:0] expq[$];
        logic [16:0] e;
        logic [64:0] m;
        logic [15:0] d;
        logic [7:0] n;
        logic [2:0] op;
        logic acc, cons, v, cf, ordy;
        logic [16:0] got;
        int errs = 0;
        for (int cyc = 0; cyc < 180; cyc++) begin
            if (cyc == 0) begin v = 1'b1; op = 3'b100; d = 16'h8001; n = 8'd0; cf = 1'b0; end
            else if (cyc == 1) begin v = 1'b1; op = 3'b010; d = 16'h8001; n = 8'd15; cf = 1'b1; end
            else begin
                v = cyc < 160 && $urandom_range(0, 3) != 0;
                op = 3'($urandom); d = 16'($urandom); cf = 1'($urandom);
                n = $urandom_range(0, 1) ? 8'($urandom_range(0, 20)) : 8'($urandom);
            end
            ordy = cyc < 2 || cyc >= 160 || $urandom_range(0, 9) < 7;
            tick16(v, op, d, n, cf, ordy, acc, cons, got);
            if (cons) begin
                e = expq.size() > 0 ? expq.pop_front() : 17'h0;
                checks++;
                if (got !== e) begin
                    fails++;
                    if (errs++ < 10) $display("FAIL random16: {c,out}=%h, required %h", got, e);
                end
            end
            if (acc) begin
                if (cyc == 0) e = {1'b1, 16'hFFFF};
                else if (cyc == 1) e = {1'b0, 16'h0001};
                else begin
                    m = model(16, op, {48'd0, d}, int'(n), cf);
                    e = {m[64], m[15:0]};
                end
                expq.push_back(e);
            end
        end
        checks++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL random16_drain: %0d results missing, required 0", expq.size());
        end
    endtask

    initial begin
        b32.in_valid = 1'b0; b32.shift_op = '0; b32.shift_data = '0; b32.shift_num = '0; b32.carry_flag = 1'b0; b32.out_ready = 1'b1;
        b16.in_valid = 1'b0; b16.shift_op = '0; b16.shift_data = '0; b16.shift_num = '0; b16.carry_flag = 1'b0; b16.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_back_pressure();
        test_random();
        test_w16();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/barrel_shift_pipe.md
Name: barrel_shift_pipe

Overview:
- Parametrised, two-stage pipelined successor to the team's 32-bit combinational barrel shifter.
- Performs the ARM data-processing shifter operations (LSL/LSR/ASR/ROR/RRX, immediate and register forms) on DATA_W-bit operands and produces the shifter carry-out.
- Uses a valid/ready handshake on both sides.
- Sits between the operand-fetch logic and the ALU in the multi-cycle CPU datapath, and is also driven by the board test wrapper.

Parameters:
- DATA_W, 32, operand width; power of two, 8..64.
- AMT_W, 8, width of the shift-amount field (register form uses all bits; immediate form uses the low clog2(DATA_W) bits).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts beat this cycle
- shift_data  in  DATA_W  operand
- shift_num  in  AMT_W  shift amount
- shift_op  in  3  operation code
- carry_flag  in  1  current C flag
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- shift_out  out  DATA_W  shifted result
- shift_carry_out  out  1  shifter carry-out

Behaviour:
- Reset: while rst_n=0 all pipeline valids clear. out_valid=0, shift_out=0, shift_carry_out=0; in_ready=1 after reset. Deassertion takes effect at the next clk edge.
- A beat is accepted when in_valid & in_ready. A result is consumed when out_valid & out_ready.
- Stage 1 (decode register):
  - Captures the operand and C flag.
  - Normalises op/amount to {kind, eff_amt, special}, where special is ZERO_AMT, FULL (amt == DATA_W), OVER (amt > DATA_W) or RRX.
- Stage 2 (shift register): log2(DATA_W) mux layers compute the result and carry; the output is registered.
- Latency: an accepted beat appears on out_valid exactly 2 cycles later if out_ready stays 1. Throughput is 1 beat/cycle.
- Stall:
  - Each stage loads when it is empty or its downstream stage is advancing.
  - in_ready = !s1_valid | s2_advance, where s2_advance = !out_valid | out_ready.
  - in_ready is combinational from out_ready; there is no skid buffer.
  - While out_valid=1 and out_ready=0, shift_out and shift_carry_out are held stable.
- shift_op encoding (n = amount, W = DATA_W):
  - 000 LSL imm: n=0 → data unchanged, C=carry_flag; else data<<n, C = bit W-n.
  - 001 LSL reg: n=0 → unchanged, C=carry_flag; 1..W-1 as imm; n=W → 0, C=bit0; n>W → 0, C=0.
  - 010 LSR imm: n=0 means shift by W → result 0, C=bit W-1; else logical right shift, C = bit n-1.
  - 011 LSR reg: n=0 → unchanged, C=carry_flag; n=W → 0, C=bit W-1; n>W → 0, C=0.
  - 100 ASR imm: n=0 means W → all bits = sign, C=sign; else arithmetic right shift, C = bit n-1.
  - 101 ASR reg: n=0 → unchanged, C=carry_flag; n≥W → all bits = sign, C=sign.
  - 110 ROR imm: n=0 → RRX: {carry_flag, data[W-1:1]}, C=bit0; else rotate right by n, C = bit n-1.
  - 111 ROR reg: n=0 → unchanged, C=carry_flag; n[log2W-1:0]=0 with n≠0 → unchanged, C=bit W-1; else rotate right by n mod W, C = result bit W-1.
- Immediate forms ignore shift_num bits above log2(W).
- Simultaneous accept and consume in the same cycle is legal; no beat is lost or duplicated.
- If rst_n is asserted mid-stream, all in-flight beats are discarded.

Optional Feature:
- SHIFT_ZN_FLAGS_EN defined: adds outputs out_zero (shift_out==0) and out_neg (shift_out[DATA_W-1]). Both are registered alongside shift_out, reset to 0 and held during a stall.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset with in_valid=1 held → out_valid=0, shift_out=0 during reset; first beat accepted on the first edge after release, out_valid 2 cycles later.
- LSL imm: data=0x8000_0001, n=1, op=000 → 0x0000_0002, C=1. Same beat with n=0, carry_flag=0 → 0x8000_0001, C=0.
- Register-form boundaries, data=0x8000_0001:
  - op=001, n=32 → 0, C=1.
  - op=011, n=33 → 0, C=0.
  - op=101, n=200 → 0xFFFF_FFFF, C=1.
  - op=111, n=64 → unchanged, C=1.
- RRX/ROR: data=0x0000_0003, carry_flag=1, op=110, n=0 → 0x8000_0001, C=1. op=110, n=4 → 0x3000_0000, C=0.
- Back-pressure: stream 4 beats with out_ready low for 3 cycles mid-stream → in_ready drops once both stages are full, output held stable, all 4 results delivered in order with no drop or duplication.
- DATA_W=16 build: data=0x8001, op=100, n=0 → 0xFFFF, C=1. op=010, n=15 → 0x0001, C=0.
